// File: rtl/rtc_pkg.sv
// rtc_pkg -- shared definitions for the RTC bus sequencer.
//   * micro port ids (0x20..0x24)
//   * bus-cycle FSM state encoding
//   * bus control bundle and the state -> pin decode
package rtc_pkg;

    localparam logic [7:0] PORT_ADDR     = 8'h20;  // write: latch address
    localparam logic [7:0] PORT_WDATA    = 8'h21;  // write: latch data, start write cycle
    localparam logic [7:0] PORT_RD_START = 8'h22;  // write: start read cycle
    localparam logic [7:0] PORT_RDATA    = 8'h23;  // read : read-data register
    localparam logic [7:0] PORT_STATUS   = 8'h24;  // read : {6'b0, err, busy}

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        A_SETUP  = 4'd1,
        A_STROBE = 4'd2,
        A_HOLD   = 4'd3,
        GAP      = 4'd4,
        D_SETUP  = 4'd5,
        D_STROBE = 4'd6,
        D_HOLD   = 4'd7,
        DONE     = 4'd8
    } state_t;

    // Active-low RTC pins plus bus driver enable and data-vs-address select.
    typedef struct packed {
        logic cs;
        logic ad;
        logic rd;
        logic wr;
        logic oe;
        logic sel_data;
    } bus_ctrl_t;

    // Pin levels for a given state. The address phase always strobes WR,
    // whatever the cycle type; only the data phase distinguishes read/write.
    // In a read data phase the driver is off for the whole phase, so the
    // bus is never driven while RD is low.
    function automatic bus_ctrl_t decode_bus(input state_t st, input logic op_rd);
        bus_ctrl_t c;
        c.cs       = 1'b1;
        c.ad       = 1'b1;
        c.rd       = 1'b1;
        c.wr       = 1'b1;
        c.oe       = 1'b0;
        c.sel_data = 1'b0;
        case (st)
            A_SETUP, A_HOLD: begin
                c.cs = 1'b0;
                c.ad = 1'b0;
                c.oe = 1'b1;
            end
            A_STROBE: begin
                c.cs = 1'b0;
                c.ad = 1'b0;
                c.oe = 1'b1;
                c.wr = 1'b0;
            end
            D_SETUP, D_HOLD: begin
                c.cs       = 1'b0;
                c.oe       = ~op_rd;
                c.sel_data = 1'b1;
            end
            D_STROBE: begin
                c.cs       = 1'b0;
                c.oe       = ~op_rd;
                c.sel_data = 1'b1;
                if (op_rd) c.rd = 1'b0;
                else       c.wr = 1'b0;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer -- 8-bit reload/down-counter that times each bus phase.
//   clk       : system clock
//   reset     : asynchronous active-low reset (counter -> 0)
//   load      : state entry; reload to T_PHASE-1
//   phase_end : counter is at 0, current phase ends on this edge
module rtc_phase_timer #(
    parameter int unsigned T_PHASE = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic phase_end
);

    localparam logic [7:0] RELOAD = 8'(T_PHASE - 1);

    logic [7:0] cnt;

    // Saturates at 0 so an idle FSM sees a steady phase_end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          cnt <= '0;
        else if (load)       cnt <= RELOAD;
        else if (cnt != '0)  cnt <= cnt - 8'd1;
    end

    assign phase_end = (cnt == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer -- micro-port driven sequencer for a multiplexed
// address/data RTC bus. Each transaction is: address phase (setup, WR
// strobe, hold), bus-release gap, data phase (setup, RD or WR strobe,
// hold), then one DONE cycle.
//   clk, reset          : clock, asynchronous active-low reset
//   chipsel             : qualifies micro accesses
//   writestrobe         : micro write strobe (one cycle)
//   readstrobe          : micro read strobe (one cycle)
//   dir_in, dato_in     : micro port id and write data
//   data_out_micro      : registered micro read data (1-cycle latency)
//   dat_RTC             : bidirectional RTC address/data bus
//   CS, AD, RD, WR      : RTC bus controls, active low
//   busy                : transaction in progress
module rtc_bus_sequencer
    import rtc_pkg::*;
#(
    parameter int unsigned T_PHASE = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipsel,
    input  logic       writestrobe,
    input  logic       readstrobe,
    input  logic [7:0] dir_in,
    input  logic [7:0] dato_in,
    output logic [7:0] data_out_micro,
    inout  wire  [7:0] dat_RTC,
    output logic       CS,
    output logic       AD,
    output logic       RD,
    output logic       WR,
    output logic       busy
);

    state_t    state, state_nxt;
    logic      op_rd;
    logic      err;
    logic [7:0] addr_q, wdata_q, rdata_q;
    logic [7:0] micro_rdata;
    logic      phase_end, load;
    logic      wr_addr, wr_wdata, wr_rdst, rd_status;
    logic      start_wr, start_rd, err_set;
    bus_ctrl_t ctrl;

    // Micro port decode
    assign wr_addr   = chipsel & writestrobe & (dir_in == PORT_ADDR);
    assign wr_wdata  = chipsel & writestrobe & (dir_in == PORT_WDATA);
    assign wr_rdst   = chipsel & writestrobe & (dir_in == PORT_RD_START);
    assign rd_status = chipsel & readstrobe  & (dir_in == PORT_STATUS);

    assign busy     = (state != IDLE);
    assign start_wr = wr_wdata & ~busy;
    assign start_rd = wr_rdst  & ~busy;
    // Any register write or start while busy is dropped and flagged, so the
    // running cycle keeps the values it latched.
    assign err_set  = busy & (wr_addr | wr_wdata | wr_rdst);

    rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .phase_end (phase_end)
    );

    // Every state change reloads the timer, so each timed state starts
    // from a full T_PHASE count.
    assign load = (state_nxt != state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_wr || start_rd) state_nxt = A_SETUP;
            A_SETUP:  if (phase_end) state_nxt = A_STROBE;
            A_STROBE: if (phase_end) state_nxt = A_HOLD;
            A_HOLD:   if (phase_end) state_nxt = GAP;
            GAP:      if (phase_end) state_nxt = D_SETUP;
            D_SETUP:  if (phase_end) state_nxt = D_STROBE;
            D_STROBE: if (phase_end) state_nxt = D_HOLD;
            D_HOLD:   if (phase_end) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Micro read mux; status and read data only visible with chipsel.
    always_comb begin
        micro_rdata = '0;
        if (chipsel) begin
            case (dir_in)
                PORT_RDATA:  micro_rdata = rdata_q;
                PORT_STATUS: micro_rdata = {6'b0, err, busy};
                default:     micro_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_rd          <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            err            <= 1'b0;
            data_out_micro <= '0;
        end else begin
            if (wr_addr && !busy) addr_q <= dato_in;
            if (start_wr) begin
                wdata_q <= dato_in;
                op_rd   <= 1'b0;
            end
            if (start_rd) op_rd <= 1'b1;
            // Capture on the last RD-low cycle, when RTC data has settled.
            if (state == D_STROBE && op_rd && phase_end) rdata_q <= dat_RTC;
            // A new error in the same cycle as a status read survives it.
            if (err_set)        err <= 1'b1;
            else if (rd_status) err <= 1'b0;
            data_out_micro <= micro_rdata;
        end
    end

    // Bus pins decode straight from the state register, so reset drops
    // them to idle levels without waiting for a clock.
    assign ctrl    = decode_bus(state, op_rd);
    assign CS      = ctrl.cs;
    assign AD      = ctrl.ad;
    assign RD      = ctrl.rd;
    assign WR      = ctrl.wr;
    assign dat_RTC = ctrl.oe ? (ctrl.sel_data ? wdata_q : addr_q) : 8'hzz;

endmodule
